// File: rtl/spi_adc_responder_if.sv
// Signal bundle between an SPI master (plus sample source) and spi_adc_responder.
interface spi_adc_responder_if #(
    parameter int unsigned DATA_W = 12
);
    logic              cs_n;
    logic              sck;
    logic              miso;
    logic              miso_oe;
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic              sample_ack;
    logic              stale;
    logic              busy;
    logic              frame_done;
    logic              aborted;

    modport master (
        output cs_n, sck, sample_in, sample_valid,
        input  miso, miso_oe, sample_ack, stale, busy, frame_done, aborted
    );

    modport slave (
        input  cs_n, sck, sample_in, sample_valid,
        output miso, miso_oe, sample_ack, stale, busy, frame_done, aborted
    );
endinterface

// File: rtl/spi_adc_responder.sv
// Serial ADC emulator: latches a sample on chip-select fall and shifts it out
// MSB-first in SPI mode 0 after LEAD_BITS zero bits. All outputs are registered.
module spi_adc_responder #(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned LEAD_BITS = 3
) (
    input logic                clk,
    input logic                reset,
    spi_adc_responder_if.slave bus
);
    localparam int unsigned FRAME_LEN = LEAD_BITS + DATA_W;
    localparam int unsigned K_W       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    logic cs_meta, cs_sync, cs_prev;
    logic sck_meta, sck_sync, sck_prev;
    logic cs_fall, cs_rise, sck_fall;

    state_t            state_q;
    logic [K_W-1:0]    k_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] last_sample_q;
    logic              miso_q, miso_oe_q, busy_q, stale_q;
    logic              ack_q, done_q, aborted_q;

    // Bring cs_n and sck into the clk domain; the third flop gives edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_meta  <= 1'b1;
            cs_sync  <= 1'b1;
            cs_prev  <= 1'b1;
            sck_meta <= 1'b0;
            sck_sync <= 1'b0;
            sck_prev <= 1'b0;
        end else begin
            cs_meta  <= bus.cs_n;
            cs_sync  <= cs_meta;
            cs_prev  <= cs_sync;
            sck_meta <= bus.sck;
            sck_sync <= sck_meta;
            sck_prev <= sck_sync;
        end
    end

    assign cs_fall  = cs_prev & ~cs_sync;
    assign cs_rise  = ~cs_prev & cs_sync;
    assign sck_fall = sck_prev & ~sck_sync;

    // Frame bit idx: zero during the lead-in, then the word MSB-first.
    function automatic logic frame_bit(input logic [DATA_W-1:0] data, input logic [K_W-1:0] idx);
        logic [DATA_W-1:0] shifted;
        if (32'(idx) < LEAD_BITS) begin
            return 1'b0;
        end
        shifted = data << (32'(idx) - LEAD_BITS);
        return shifted[DATA_W-1];
    endfunction

    // Frame state machine with registered outputs; cs edges take priority over sck.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            k_q           <= '0;
            shreg_q       <= '0;
            last_sample_q <= '0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            busy_q        <= 1'b0;
            stale_q       <= 1'b0;
            ack_q         <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_q   <= StShift;
                        k_q       <= '0;
                        busy_q    <= 1'b1;
                        miso_oe_q <= 1'b1;
                        if (bus.sample_valid) begin
                            shreg_q       <= bus.sample_in;
                            last_sample_q <= bus.sample_in;
                            ack_q         <= 1'b1;
                            stale_q       <= 1'b0;
                            miso_q        <= frame_bit(bus.sample_in, '0);
                        end else begin
                            // No fresh sample: repeat the previous one and flag it.
                            shreg_q <= last_sample_q;
                            stale_q <= 1'b1;
                            miso_q  <= frame_bit(last_sample_q, '0);
                        end
                    end
                end
                StShift: begin
                    if (cs_rise) begin
                        state_q   <= StIdle;
                        aborted_q <= 1'b1;
                        miso_oe_q <= 1'b0;
                        busy_q    <= 1'b0;
                        miso_q    <= 1'b0;
                    end else if (sck_fall) begin
                        if (k_q == K_W'(FRAME_LEN - 1)) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            miso_q  <= 1'b0;
                        end else begin
                            k_q    <= k_q + K_W'(1);
                            miso_q <= frame_bit(shreg_q, k_q + K_W'(1));
                        end
                    end
                end
                StDone: begin
                    if (cs_rise) begin
                        state_q   <= StIdle;
                        miso_oe_q <= 1'b0;
                        busy_q    <= 1'b0;
                        miso_q    <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.miso       = miso_q;
    assign bus.miso_oe    = miso_oe_q;
    assign bus.busy       = busy_q;
    assign bus.stale      = stale_q;
    assign bus.sample_ack = ack_q;
    assign bus.frame_done = done_q;
    assign bus.aborted    = aborted_q;
endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: directed SPI frames against a frame-level model.
module tb_spi_adc_responder;
    localparam int DATA_W    = 12;
    localparam int LEAD_BITS = 3;
    localparam int FRAME_LEN = LEAD_BITS + DATA_W;

    localparam int EV_NONE     = 0;
    localparam int EV_CS_FALL  = 1;
    localparam int EV_CS_RISE  = 2;
    localparam int EV_SCK_FALL = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    spi_adc_responder_if #(.DATA_W(DATA_W)) bus ();

    spi_adc_responder #(
        .DATA_W   (DATA_W),
        .LEAD_BITS(LEAD_BITS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Frame-level model: 0 idle, 1 shifting, 2 done
    int   m_state = 0;
    int   m_falls = 0;
    int   m_data  = 0;
    int   m_last  = 0;
    logic e_miso = 0, e_oe = 0, e_busy = 0, e_stale = 0;
    logic e_ack = 0, e_done = 0, e_abort = 0;

    int n_cmp  = 0;
    int n_fail = 0;
    bit check_en = 0;
    int n_ack = 0, n_done = 0, n_abort = 0;

    // Bit k of a frame: the sample as a FRAME_LEN-bit number, MSB first.
    function automatic logic model_bit(input int data, input int k);
        if (k >= FRAME_LEN) return 1'b0;
        return ((data >> (FRAME_LEN - 1 - k)) & 1) != 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_apply(input int kind);
        case (kind)
            EV_CS_FALL: if (m_state == 0) begin
                m_state = 1;
                m_falls = 0;
                e_busy  = 1;
                e_oe    = 1;
                if (bus.sample_valid) begin
                    m_data  = int'(bus.sample_in);
                    m_last  = m_data;
                    e_ack   = 1;
                    e_stale = 0;
                end else begin
                    m_data  = m_last;
                    e_stale = 1;
                end
                e_miso = model_bit(m_data, 0);
            end
            EV_CS_RISE: begin
                if (m_state == 1) e_abort = 1;
                if (m_state != 0) begin
                    m_state = 0;
                    e_oe    = 0;
                    e_busy  = 0;
                    e_miso  = 0;
                end
            end
            EV_SCK_FALL: if (m_state == 1) begin
                m_falls++;
                if (m_falls == FRAME_LEN) begin
                    m_state = 2;
                    e_miso  = 0;
                    e_done  = 1;
                end else begin
                    e_miso = model_bit(m_data, m_falls);
                end
            end
            default: ;
        endcase
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check("miso", bus.miso, e_miso);
            check("miso_oe", bus.miso_oe, e_oe);
            check("busy", bus.busy, e_busy);
            check("stale", bus.stale, e_stale);
            check("sample_ack", bus.sample_ack, e_ack);
            check("frame_done", bus.frame_done, e_done);
            check("aborted", bus.aborted, e_abort);
        end
    end

    // Pulse counters for the per-scenario totals.
    always @(negedge clk) begin
        if (check_en) begin
            if (bus.sample_ack === 1'b1) n_ack++;
            if (bus.frame_done === 1'b1) n_done++;
            if (bus.aborted === 1'b1) n_abort++;
        end
    end

    // One pin change; the model follows 3 clocks later; 8 clocks per call.
    task automatic ev(input logic cs_v, input logic sck_v, input int kind, output logic cap);
        @(posedge clk); #1;
        cap = bus.miso;
        bus.cs_n = cs_v;
        bus.sck  = sck_v;
        repeat (3) @(posedge clk); #1;
        model_apply(kind);
        @(posedge clk); #1;
        e_ack   = 0;
        e_done  = 0;
        e_abort = 0;
        repeat (3) @(posedge clk);
    endtask

    task automatic frame(input int data, input bit valid, input int pulses, output int bits);
        logic c;
        bus.sample_in    = 12'(data);
        bus.sample_valid = valid;
        ev(1'b0, 1'b0, EV_CS_FALL, c);
        bus.sample_in = 12'(~data);   // must be ignored mid-frame
        bits = 0;
        for (int i = 0; i < pulses; i++) begin
            ev(1'b0, 1'b1, EV_NONE, c);
            bits = (bits << 1) | int'(c);
            ev(1'b0, 1'b0, EV_SCK_FALL, c);
        end
    endtask

    task automatic end_frame();
        logic c;
        ev(1'b1, 1'b0, EV_CS_RISE, c);
    endtask

    initial begin
        int   bits;
        int   a0, d0, b0;
        logic c;

        reset            = 1'b1;
        bus.cs_n         = 1'b1;
        bus.sck          = 1'b0;
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        reset    = 1'b0;
        check_en = 1;
        check("reset_oe", bus.miso_oe, 1'b0);
        check("reset_busy", bus.busy, 1'b0);

        // Normal frame
        a0 = n_ack; d0 = n_done;
        frame(32'hA5C, 1'b1, 15, bits);
        check("normal_bits", bits, 32'h0A5C);
        check("normal_ack_count", n_ack - a0, 1);
        check("normal_done_count", n_done - d0, 1);
        check("normal_stale", bus.stale, 1'b0);
        check("normal_miso_after", bus.miso, 1'b0);
        end_frame();
        check("normal_busy_after_rise", bus.busy, 1'b0);

        // Over-clocking: 20 pulses
        d0 = n_done;
        frame(32'hFFF, 1'b1, 20, bits);
        check("over_bits", bits, 32'h1FFE0);
        check("over_done_count", n_done - d0, 1);
        check("over_oe_held", bus.miso_oe, 1'b1);
        end_frame();
        check("over_oe_after_rise", bus.miso_oe, 1'b0);

        // Abort after 5 falls
        d0 = n_done; b0 = n_abort;
        frame(32'h5A5, 1'b1, 5, bits);
        check("abort_bits", bits, 32'h1);
        end_frame();
        check("abort_count", n_abort - b0, 1);
        check("abort_no_done", n_done - d0, 0);
        check("abort_oe", bus.miso_oe, 1'b0);
        check("abort_busy", bus.busy, 1'b0);

        // Restart at bit 0, then stale re-send, then fresh sample
        frame(32'h123, 1'b1, 15, bits);
        check("restart_bits", bits, 32'h0123);
        end_frame();
        a0 = n_ack;
        frame(32'hFFF, 1'b0, 15, bits);
        check("stale_bits", bits, 32'h0123);
        check("stale_flag", bus.stale, 1'b1);
        check("stale_no_ack", n_ack - a0, 0);
        end_frame();
        check("stale_kept", bus.stale, 1'b1);
        frame(32'h456, 1'b1, 15, bits);
        check("fresh_bits", bits, 32'h0456);
        check("fresh_stale", bus.stale, 1'b0);
        end_frame();

        // Reset after 7 bits
        frame(32'h777, 1'b1, 7, bits);
        check("prereset_bits", bits, 32'h7);
        @(posedge clk); #1;
        reset    = 1'b1;
        bus.cs_n = 1'b1;
        bus.sck  = 1'b0;
        @(posedge clk); #1;
        reset   = 1'b0;
        m_state = 0; m_last = 0; m_falls = 0;
        e_miso = 0; e_oe = 0; e_busy = 0; e_stale = 0;
        e_ack = 0; e_done = 0; e_abort = 0;
        check("rst_miso", bus.miso, 1'b0);
        check("rst_oe", bus.miso_oe, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        repeat (4) @(posedge clk);
        d0 = n_done;
        frame(32'h000, 1'b1, 15, bits);
        check("postreset_bits", bits, 32'h0);
        check("postreset_done_count", n_done - d0, 1);
        end_frame();

        // Collision: cs rise and the last sck fall together
        d0 = n_done; b0 = n_abort;
        frame(32'h0F0, 1'b1, 14, bits);
        check("collide_bits", bits, 32'h78);
        ev(1'b0, 1'b1, EV_NONE, c);
        ev(1'b1, 1'b0, EV_CS_RISE, c);
        check("collide_abort", n_abort - b0, 1);
        check("collide_no_done", n_done - d0, 0);
        check("collide_oe", bus.miso_oe, 1'b0);
        check("collide_busy", bus.busy, 1'b0);
        frame(32'h321, 1'b1, 15, bits);
        check("after_collide_bits", bits, 32'h0321);
        end_frame();

        repeat (4) @(posedge clk);
        check_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
